// File: rtl/regfile_pkg.sv
// Shared register-file definitions: width defaults, opcodes, index-width helper.
// Build option: define REGFILE_SCOREBOARD_BYPASS_EN for same-cycle write-back bypass.
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

`ifdef REGFILE_SCOREBOARD_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  // Major opcodes shared with the immediate generator and decoder.
  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_REG    = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111
  } opcode_e;

  function automatic int idx_width(input int nreg);
    return $clog2(nreg);
  endfunction

endpackage

// File: rtl/regfile_rdport.sv
// Single read port: zero-register check, optional write-back bypass, hazard flag.
// Bypass behaviour follows REGFILE_SCOREBOARD_BYPASS_EN through regfile_pkg::BYPASS_EN.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int AW   = idx_width(NREG)
) (
  input  logic            rst,
  input  logic [AW-1:0]   idx,
  input  logic            en,
  input  logic [XLEN-1:0] regs [NREG],
  input  logic [NREG-1:0] busy,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] data,
  output logic            hazard
);

  logic wb_hit;

  always_comb begin
    wb_hit = BYPASS_EN && wb_valid && (wb_rd == idx);
    data   = '0;
    hazard = 1'b0;
    if (rst && (idx != '0)) begin
      data   = wb_hit ? wb_data : regs[idx];
      hazard = en && busy[idx] && !wb_hit;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with busy scoreboard; x0 reads zero and is never reserved.
// Define REGFILE_SCOREBOARD_BYPASS_EN to enable same-cycle write-back bypass.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRP  = 2,
  parameter int AW   = idx_width(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRP*AW-1:0]   rd_idx,
  input  logic [NRP-1:0]      rd_en,
  output logic [NRP*XLEN-1:0] rd_data,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  input  logic                iss_we,
  output logic                stall,
  input  logic                wb_valid,
  input  logic [AW-1:0]       wb_rd,
  input  logic [XLEN-1:0]     wb_data,
  output logic [NREG-1:0]     busy_vec,
  input  logic [AW-1:0]       dbg_idx,
  output logic [XLEN-1:0]     dbg_data
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NRP-1:0]  hazard;
  logic            waw;
  logic            commit;

  genvar p;
  generate
    for (p = 0; p < NRP; p++) begin : g_rp
      regfile_rdport #(
        .XLEN (XLEN),
        .NREG (NREG),
        .AW   (AW)
      ) u_rp (
        .rst      (rst),
        .idx      (rd_idx[p*AW +: AW]),
        .en       (rd_en[p]),
        .regs     (regs),
        .busy     (busy),
        .wb_valid (wb_valid),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .data     (rd_data[p*XLEN +: XLEN]),
        .hazard   (hazard[p])
      );
    end
  endgenerate

  always_comb begin
    waw    = iss_we && (iss_rd != '0) && busy[iss_rd] &&
             !(BYPASS_EN && wb_valid && (wb_rd == iss_rd));
    stall  = rst && iss_valid && ((|hazard) || waw);
    commit = iss_valid && !stall && iss_we && (iss_rd != '0);
  end

  // Reservation is applied after the write-back clear so a new producer wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs <= '{default: '0};
      busy <= '0;
    end else begin
      if (wb_valid && (wb_rd != '0)) begin
        regs[wb_rd] <= wb_data;
        busy[wb_rd] <= 1'b0;
      end
      if (commit) begin
        busy[iss_rd] <= 1'b1;
      end
    end
  end

  assign busy_vec = busy;
  assign dbg_data = rst ? regs[dbg_idx] : '0;

  nreg_pow2: assert property (@(posedge clk) disable iff (!rst) (NREG == (1 << AW)));

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed and random checks of regfile_scoreboard against a behavioural model.
module tb_regfile_scoreboard;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRP  = 2;
  localparam int AW   = 5;

`ifdef REGFILE_SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [NRP*AW-1:0]   rd_idx;
  logic [NRP-1:0]      rd_en;
  logic [NRP*XLEN-1:0] rd_data;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                iss_we;
  logic                stall;
  logic                wb_valid;
  logic [AW-1:0]       wb_rd;
  logic [XLEN-1:0]     wb_data;
  logic [NREG-1:0]     busy_vec;
  logic [AW-1:0]       dbg_idx;
  logic [XLEN-1:0]     dbg_data;

  int errors = 0;
  int checks = 0;

  logic [XLEN-1:0] mregs [NREG];
  bit              mbusy [NREG];
  bit              exp_stall;

  regfile_scoreboard #(
    .XLEN (XLEN),
    .NREG (NREG),
    .NRP  (NRP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (rd_idx),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_we    (iss_we),
    .stall     (stall),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .busy_vec  (busy_vec),
    .dbg_idx   (dbg_idx),
    .dbg_data  (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, got, exp);
    end
  endtask

  function automatic bit hit(input int i);
    return BYP && wb_valid && (int'(wb_rd) == i);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) begin
      mregs[i] = '0;
      mbusy[i] = 1'b0;
    end
  endtask

  task automatic evaluate();
    bit any_haz;
    bit waw;
    int idx;
    logic [XLEN-1:0] e;
    logic [NREG-1:0] ebusy;
    any_haz = 1'b0;
    for (int p = 0; p < NRP; p++) begin
      idx = int'(rd_idx[p*AW +: AW]);
      if (!rst || idx == 0) e = '0;
      else if (hit(idx))    e = wb_data;
      else                  e = mregs[idx];
      chk($sformatf("rd_data%0d", p), rd_data[p*XLEN +: XLEN], e);
      if (rd_en[p] && idx != 0 && mbusy[idx] && !hit(idx)) any_haz = 1'b1;
    end
    waw = iss_we && iss_rd != 0 && mbusy[int'(iss_rd)] && !hit(int'(iss_rd));
    exp_stall = rst && iss_valid && (any_haz || waw);
    chk("stall", {31'b0, stall}, {31'b0, exp_stall});
    for (int i = 0; i < NREG; i++) ebusy[i] = mbusy[i];
    chk("busy_vec", busy_vec, ebusy);
    chk("dbg_data", dbg_data, rst ? mregs[int'(dbg_idx)] : '0);
  endtask

  task automatic cycle();
    @(negedge clk);
    evaluate();
    @(posedge clk);
    if (rst) begin
      if (wb_valid && wb_rd != 0) begin
        mregs[int'(wb_rd)] = wb_data;
        mbusy[int'(wb_rd)] = 1'b0;
      end
      if (iss_valid && !exp_stall && iss_we && iss_rd != 0) mbusy[int'(iss_rd)] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    rd_idx = '0; rd_en = '0; iss_valid = 1'b0; iss_rd = '0; iss_we = 1'b0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0; dbg_idx = '0;
  endtask

  initial begin
    idle();
    model_clear();

    // 1: reset state, reading x5 on both ports
    rd_idx = {5'd5, 5'd5}; rd_en = 2'b11; dbg_idx = 5'd5; iss_valid = 1'b1;
    #2 evaluate();
    #1 rst = 1'b1;
    cycle();

    // 2: reserve x3, read it while busy, then write it back
    idle(); iss_valid = 1'b1; iss_we = 1'b1; iss_rd = 5'd3;
    cycle();
    idle(); iss_valid = 1'b1; rd_idx = {5'd0, 5'd3}; rd_en = 2'b01;
    cycle();
    chk("x3_stall", {31'b0, stall}, 32'd1);
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
    cycle();
    wb_valid = 1'b0; dbg_idx = 5'd3;
    cycle();
    chk("x3_data", rd_data[XLEN-1:0], 32'hDEADBEEF);

    // 3: x0 writes and reservations are ignored
    idle(); wb_valid = 1'b1; wb_rd = '0; wb_data = 32'h1234;
    iss_valid = 1'b1; iss_we = 1'b1; iss_rd = '0; rd_en = 2'b11;
    cycle();
    wb_valid = 1'b0;
    cycle();
    chk("busy0", {31'b0, busy_vec[0]}, 32'd0);

    // 4: reserve and write back x7 in the same cycle; the reservation wins
    idle(); iss_valid = 1'b1; iss_we = 1'b1; iss_rd = 5'd7;
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'hA5;
    cycle();
    idle(); dbg_idx = 5'd7; rd_idx = {5'd7, 5'd7};
    cycle();
    chk("busy7", {31'b0, busy_vec[7]}, 32'd1);
    chk("dbg7", dbg_data, 32'hA5);

    // 5: WAW on x9
    idle(); iss_valid = 1'b1; iss_we = 1'b1; iss_rd = 5'd9;
    cycle();
    cycle();
    chk("waw_stall", {31'b0, stall}, 32'd1);
    wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h55;
    cycle();
    wb_valid = 1'b0;
    cycle();

    // 6: reserve x4 and x6, then reset mid-sequence
    idle(); iss_valid = 1'b1; iss_we = 1'b1; iss_rd = 5'd4;
    cycle();
    iss_rd = 5'd6;
    cycle();
    rst = 1'b0;
    #1;
    model_clear();
    idle(); iss_valid = 1'b1; rd_idx = {5'd6, 5'd4}; rd_en = 2'b11;
    iss_we = 1'b1; iss_rd = 5'd6; dbg_idx = 5'd4;
    evaluate();
    cycle();
    #2 rst = 1'b1;
    wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'hCAFE0004;
    cycle();
    idle(); rd_idx = {5'd6, 5'd4}; rd_en = 2'b11; iss_valid = 1'b1;
    cycle();

    // Random traffic over a small index range to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < NRP; p++) rd_idx[p*AW +: AW] = AW'($urandom_range(15));
      rd_en     = NRP'($urandom);
      iss_valid = 1'($urandom);
      iss_we    = 1'($urandom);
      iss_rd    = AW'($urandom_range(15));
      wb_valid  = ($urandom_range(3) != 0);
      wb_rd     = AW'($urandom_range(15));
      wb_data   = $urandom;
      dbg_idx   = AW'($urandom_range(15));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
